// File: rtl/scaad_pkg.sv
// Shared types for the dispensing path: FSM states, BCD digit/word types
// and the single-digit BCD adder used by the volume accumulator.
package scaad_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DOSIFICANDO = 2'd1,
      COMPLETO    = 2'd2,
      FALLA       = 2'd3
   } estado_t;

   typedef logic [3:0]           bcd_digito_t;
   typedef bcd_digito_t [3:0]    bcd_palabra_t;

   typedef struct packed {
      logic        acarreo;
      bcd_digito_t digito;
   } bcd_suma_t;

   localparam bcd_palabra_t BCD_MAX = 16'h9999;

   // Adds a digit, an addend (0..9) and a carry-in; results above 9 wrap with carry-out.
   function automatic bcd_suma_t bcd_sumar_digito(input bcd_digito_t a,
                                                  input logic [3:0]  b,
                                                  input logic        cin);
      logic [4:0] s;
      bcd_suma_t  r;
      s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      if (s > 5'd9) begin
         r.acarreo = 1'b1;
         r.digito  = 4'(s - 5'd10);
      end else begin
         r.acarreo = 1'b0;
         r.digito  = s[3:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_acumulador.sv
// Four-digit BCD accumulator: adds one BCD step per inc with ripple carry,
// saturating at 9999. Exposes the next value so the caller can compare ahead.
module bcd_acumulador
   import scaad_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   input  logic [3:0]   paso,
   output bcd_palabra_t cuenta,
   output bcd_palabra_t cuenta_sig
);

   bcd_palabra_t r_cuenta;
   bcd_palabra_t w_suma;
   bcd_suma_t    w_parcial;
   logic         w_acarreo;

   always_comb begin
      w_suma    = '0;
      w_acarreo = 1'b0;
      w_parcial = '0;
      for (int i = 0; i < 4; i++) begin
         w_parcial = bcd_sumar_digito(r_cuenta[i], (i == 0) ? paso : 4'd0, w_acarreo);
         w_suma[i] = w_parcial.digito;
         w_acarreo = w_parcial.acarreo;
      end

      if (clr) begin
         cuenta_sig = '0;
      end else if (!inc) begin
         cuenta_sig = r_cuenta;
      end else if (w_acarreo) begin
         cuenta_sig = BCD_MAX;
      end else begin
         cuenta_sig = w_suma;
      end
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cuenta <= '0;
      end else begin
         r_cuenta <= cuenta_sig;
      end
   end

   assign cuenta = r_cuenta;

endmodule

// File: rtl/control_dosificacion.sv
// Dose sequencer: latches a BCD target, opens the valve, counts synchronized
// flow pulses and closes on target, abort or no-flow timeout.
module control_dosificacion
   import scaad_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 50_000_000,
   parameter int unsigned ML_PER_PULSE = 2,
   parameter int unsigned TIMEOUT_MS   = 2000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] objetivo_ml,
   input  logic        pulso_caudal,
   output logic        valvula,
   output logic [15:0] mililitros,
   output logic        ocupado,
   output logic        listo,
   output logic        error_flujo
);

   localparam int unsigned LIMITE    = (CLK_HZ / 1000) * TIMEOUT_MS;
   localparam int          TW        = $clog2(LIMITE + 1);
   localparam logic [TW-1:0] TIMER_FIN = TW'(LIMITE - 1);
   localparam logic [3:0]  PASO      = 4'(ML_PER_PULSE);

   logic [1:0]    r_sync;
   logic          r_sync_prev;
   estado_t       r_estado;
   estado_t       w_estado_sig;
   bcd_palabra_t  r_objetivo;
   logic [TW-1:0] r_timer;
   logic          r_listo;
   logic          r_error;

   logic          w_inc;
   logic          w_en_dosis;
   logic          w_aceptar;
   logic          w_cero;
   logic          w_alcanzado;
   logic          w_expira;
   bcd_palabra_t  w_cuenta;
   bcd_palabra_t  w_cuenta_sig;

   // The edge detect is combinational so a pulse lands in the adder on the third edge.
   assign w_inc       = r_sync[1] & ~r_sync_prev;
   assign w_en_dosis  = (r_estado == DOSIFICANDO);
   assign w_cero      = (objetivo_ml == '0);
   assign w_aceptar   = (r_estado == IDLE) && start && !w_cero;
   assign w_alcanzado = w_en_dosis &&
                        ((w_cuenta_sig >= r_objetivo) || (w_cuenta_sig == BCD_MAX));
   assign w_expira    = w_en_dosis && (r_timer == TIMER_FIN) && !w_inc;

   bcd_acumulador u_acumulador (
      .clk        (clk),
      .rst        (rst),
      .clr        (w_aceptar),
      .inc        (w_inc & w_en_dosis),
      .paso       (PASO),
      .cuenta     (w_cuenta),
      .cuenta_sig (w_cuenta_sig)
   );

   always_comb begin
      w_estado_sig = r_estado;
      case (r_estado)
         IDLE: begin
            if (w_aceptar) w_estado_sig = DOSIFICANDO;
         end
         DOSIFICANDO: begin
            if (abort)            w_estado_sig = IDLE;
            else if (w_alcanzado) w_estado_sig = COMPLETO;
            else if (w_expira)    w_estado_sig = FALLA;
         end
         COMPLETO: w_estado_sig = IDLE;
         FALLA:    w_estado_sig = IDLE;
         default:  w_estado_sig = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync      <= '0;
         r_sync_prev <= 1'b0;
         r_estado    <= IDLE;
         r_objetivo  <= '0;
         r_timer     <= '0;
         r_listo     <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_sync      <= {r_sync[0], pulso_caudal};
         r_sync_prev <= r_sync[1];
         r_estado    <= w_estado_sig;
         r_listo     <= ((r_estado == IDLE) && start && w_cero) ||
                        (w_en_dosis && (w_estado_sig == COMPLETO));

         if (w_aceptar) begin
            r_objetivo <= objetivo_ml;
         end

         if (w_aceptar) begin
            r_error <= 1'b0;
         end else if (w_en_dosis && (w_estado_sig == FALLA)) begin
            r_error <= 1'b1;
         end

         // Every detected pulse restarts the no-flow window.
         if (w_aceptar || w_inc || !w_en_dosis) begin
            r_timer <= '0;
         end else begin
            r_timer <= r_timer + TW'(1);
         end
      end
   end

   assign valvula     = w_en_dosis;
   assign ocupado     = w_en_dosis;
   assign listo       = r_listo;
   assign error_flujo = r_error;
   assign mililitros  = w_cuenta;

endmodule

// File: tb/tb_control_dosificacion.sv
// Directed bench for control_dosificacion with a 20-cycle no-flow timeout
// (10 kHz clock, 2 ms) and 2 ml per pulse.
module tb_control_dosificacion;

   localparam int unsigned CLK_HZ       = 10_000;
   localparam int unsigned ML_PER_PULSE = 2;
   localparam int unsigned TIMEOUT_MS   = 2;
   localparam int          LIMITE       = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] objetivo_ml;
   logic        pulso_caudal;
   logic        valvula;
   logic [15:0] mililitros;
   logic        ocupado;
   logic        listo;
   logic        error_flujo;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   control_dosificacion #(
      .CLK_HZ       (CLK_HZ),
      .ML_PER_PULSE (ML_PER_PULSE),
      .TIMEOUT_MS   (TIMEOUT_MS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .objetivo_ml  (objetivo_ml),
      .pulso_caudal (pulso_caudal),
      .valvula      (valvula),
      .mililitros   (mililitros),
      .ocupado      (ocupado),
      .listo        (listo),
      .error_flujo  (error_flujo)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_b(input string tag, input logic obs, input logic exp);
      check(tag, 16'(obs), 16'(exp));
   endtask

   task automatic pulso();
      pulso_caudal = 1'b1;
      tick();
      tick();
      pulso_caudal = 1'b0;
      tick();
      tick();
   endtask

   task automatic pulsos(input int n);
      for (int i = 0; i < n; i++) pulso();
   endtask

   task automatic iniciar(input logic [15:0] obj);
      objetivo_ml = obj;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   // Final pulse of a dose: listo and valve close land on the third edge after the rise.
   task automatic pulso_final(input string tag, input logic [15:0] ml_exp);
      pulso_caudal = 1'b1;
      tick();
      check_b({tag, "_listo_e1"}, listo, 1'b0);
      tick();
      check_b({tag, "_listo_e2"}, listo, 1'b0);
      check_b({tag, "_valv_e2"}, valvula, 1'b1);
      pulso_caudal = 1'b0;
      tick();
      check_b({tag, "_listo_e3"}, listo, 1'b1);
      check_b({tag, "_valv_e3"}, valvula, 1'b0);
      check_b({tag, "_ocup_e3"}, ocupado, 1'b0);
      check({tag, "_ml_e3"}, mililitros, ml_exp);
      tick();
      check_b({tag, "_listo_e4"}, listo, 1'b0);
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      abort        = 1'b0;
      pulso_caudal = 1'b0;
      objetivo_ml  = 16'h0000;
      tick();
      tick();
      check_b("rst_valvula", valvula, 1'b0);
      check("rst_ml", mililitros, 16'h0000);
      check_b("rst_ocupado", ocupado, 1'b0);
      check_b("rst_listo", listo, 1'b0);
      check_b("rst_error", error_flujo, 1'b0);
      rst = 1'b0;
      tick();

      // Target 0010, five pulses, with an ignored start in the middle.
      iniciar(16'h0010);
      check_b("t10_valv_open", valvula, 1'b1);
      check_b("t10_ocupado", ocupado, 1'b1);
      check("t10_ml_clr", mililitros, 16'h0000);
      pulsos(2);
      check("t10_ml_2p", mililitros, 16'h0004);
      iniciar(16'h0002);
      objetivo_ml = 16'h0000;
      check_b("busy_start_valv", valvula, 1'b1);
      check("busy_start_ml", mililitros, 16'h0004);
      pulsos(2);
      check("t10_ml_4p", mililitros, 16'h0008);
      check_b("t10_valv_4p", valvula, 1'b1);
      pulso_final("t10", 16'h0010);
      tick();
      check("t10_ml_hold", mililitros, 16'h0010);

      // Overshoot: target 0005 stops at 0006.
      iniciar(16'h0005);
      check("t05_ml_clr", mililitros, 16'h0000);
      pulsos(2);
      check("t05_ml_2p", mililitros, 16'h0004);
      pulso_final("t05", 16'h0006);

      // Abort after three pulses; later pulses in IDLE are not counted.
      iniciar(16'h0100);
      pulsos(3);
      check("abort_ml_pre", mililitros, 16'h0006);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_b("abort_valv", valvula, 1'b0);
      check_b("abort_ocupado", ocupado, 1'b0);
      check_b("abort_listo", listo, 1'b0);
      check("abort_ml", mililitros, 16'h0006);
      tick();
      check_b("abort_listo_late", listo, 1'b0);
      pulso();
      tick();
      check("idle_pulse_ml", mililitros, 16'h0006);

      // Abort coincident with the completing pulse: no listo.
      iniciar(16'h0004);
      pulso();
      check("coinc_ml_1p", mililitros, 16'h0002);
      pulso_caudal = 1'b1;
      tick();
      tick();
      pulso_caudal = 1'b0;
      abort        = 1'b1;
      tick();
      abort = 1'b0;
      check_b("coinc_listo", listo, 1'b0);
      check_b("coinc_valv", valvula, 1'b0);
      tick();
      check_b("coinc_listo_late", listo, 1'b0);

      // start and abort together in IDLE: start wins.
      objetivo_ml = 16'h0020;
      start       = 1'b1;
      abort       = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check_b("start_abort_valv", valvula, 1'b1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_b("start_abort_close", valvula, 1'b0);

      // Zero target: listo without opening the valve.
      objetivo_ml = 16'h0000;
      start       = 1'b1;
      tick();
      start = 1'b0;
      check_b("zero_listo", listo, 1'b1);
      check_b("zero_valv", valvula, 1'b0);
      check_b("zero_ocupado", ocupado, 1'b0);
      tick();
      check_b("zero_listo_end", listo, 1'b0);
      check_b("zero_valv_end", valvula, 1'b0);

      // No-flow timeout: valve open exactly LIMITE cycles.
      iniciar(16'h0050);
      repeat (LIMITE - 1) tick();
      check_b("to_valv_pre", valvula, 1'b1);
      check_b("to_err_pre", error_flujo, 1'b0);
      tick();
      check_b("to_valv", valvula, 1'b0);
      check_b("to_err", error_flujo, 1'b1);
      check_b("to_listo", listo, 1'b0);
      tick();
      check_b("to_err_sticky", error_flujo, 1'b1);
      iniciar(16'h0050);
      check_b("to_err_clr", error_flujo, 1'b0);
      check_b("to_restart_valv", valvula, 1'b1);

      // Reset mid-dose.
      pulsos(2);
      check("rstmid_ml_pre", mililitros, 16'h0004);
      rst = 1'b1;
      tick();
      check_b("rstmid_valv", valvula, 1'b0);
      check("rstmid_ml", mililitros, 16'h0000);
      check_b("rstmid_ocupado", ocupado, 1'b0);
      check_b("rstmid_listo", listo, 1'b0);
      rst = 1'b0;
      tick();

      // Reset clears a sticky error.
      iniciar(16'h0050);
      repeat (LIMITE) tick();
      check_b("to2_err", error_flujo, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_b("rst_err_clr", error_flujo, 1'b0);
      tick();

      // Carry chain and saturation at 9999.
      iniciar(16'h9999);
      pulsos(49);
      check("carry_0098", mililitros, 16'h0098);
      pulso();
      check("carry_0100", mililitros, 16'h0100);
      pulsos(449);
      check("carry_0998", mililitros, 16'h0998);
      pulso();
      check("carry_1000", mililitros, 16'h1000);
      pulsos(4499);
      check("carry_9998", mililitros, 16'h9998);
      check_b("carry_valv_9998", valvula, 1'b1);
      pulso_final("sat", 16'h9999);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
